// File: rtl/step_pkg.sv
// Shared encodings and build defaults for the CPU step controller.
package step_pkg;

    // Controller modes; HALT is only left through reset.
    typedef enum logic [1:0] {
        ST_PAUSE = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    // Simulation-friendly debounce length; the board build raises it to 2500000.
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 20;

    // Width of the retired-step counter and of the debounce counter.
    localparam int unsigned DEF_CNT_W = 32;

endpackage

// File: rtl/step_debounce.sv
// Step push-button conditioning: 2-flop synchronizer, debounce filter and
// a one-cycle press pulse on each accepted rising level.
module step_debounce
    import step_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic clk_in,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_level_q, db_level_d;
    logic             db_prev_q, db_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Accept a new level only after it has disagreed for DEBOUNCE_CYCLES cycles in a row.
    always_comb begin
        sync1_d    = btn_i;
        sync2_d    = sync1_q;
        db_level_d = db_level_q;
        db_prev_d  = db_level_q;
        cnt_d      = '0;
        if (sync2_q != db_level_q) begin
            if (cnt_q == CntLast) begin
                db_level_d = sync2_q;
                cnt_d      = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchronizer, filter and edge-detect state.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_level_q <= 1'b0;
            db_prev_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_level_q <= db_level_d;
            db_prev_q  <= db_prev_d;
            cnt_q      <= cnt_d;
        end
    end

    assign press_o = db_level_q & ~db_prev_q;

endmodule

// File: rtl/step_ctrl.sv
// CPU step controller: turns the divided clock (RUN) or debounced button
// presses (PAUSE) into single-cycle cpu_en pulses, with halt and step counting.
module step_ctrl
    import step_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             slow_clk,
    input  logic             btn_step,
    input  logic             sw_run,
    input  logic             halt_req,
    output logic             cpu_en,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] step_count
);

    logic slow_s1_q, slow_s2_q, slow_s3_q;
    logic run_s1_q, run_s2_q;
    logic tick;
    logic press;

    state_e           state_q, state_d;
    logic             cpu_en_q, cpu_en_d;
    logic             running_q, running_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] step_count_q, step_count_d;
    logic             step_src;

    step_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk_in  (clk_in),
        .rst     (rst),
        .btn_i   (btn_step),
        .press_o (press)
    );

    // Bring slow_clk and sw_run into clk_in; slow_clk gets a third stage for edge detection.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            slow_s1_q <= 1'b0;
            slow_s2_q <= 1'b0;
            slow_s3_q <= 1'b0;
            run_s1_q  <= 1'b0;
            run_s2_q  <= 1'b0;
        end else begin
            slow_s1_q <= slow_clk;
            slow_s2_q <= slow_s1_q;
            slow_s3_q <= slow_s2_q;
            run_s1_q  <= sw_run;
            run_s2_q  <= run_s1_q;
        end
    end

    assign tick = slow_s2_q & ~slow_s3_q;

    // Mode transitions and step selection; halt_req overrides any step this cycle.
    always_comb begin
        state_d  = state_q;
        step_src = 1'b0;
        case (state_q)
            ST_PAUSE: begin
                step_src = press;
                if (run_s2_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                step_src = tick;
                if (!run_s2_q) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_HALT: begin
                step_src = 1'b0;
            end
            default: begin
                state_d = ST_PAUSE;
            end
        endcase
        if (halt_req && (state_q != ST_HALT)) begin
            state_d  = ST_HALT;
            step_src = 1'b0;
        end
        cpu_en_d     = step_src;
        running_d    = (state_d == ST_RUN);
        halted_d     = (state_d == ST_HALT);
        step_count_d = step_src ? step_count_q + CNT_W'(1) : step_count_q;
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_PAUSE;
            cpu_en_q     <= 1'b0;
            running_q    <= 1'b0;
            halted_q     <= 1'b0;
            step_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cpu_en_q     <= cpu_en_d;
            running_q    <= running_d;
            halted_q     <= halted_d;
            step_count_q <= step_count_d;
        end
    end

    assign cpu_en     = cpu_en_q;
    assign running    = running_q;
    assign halted     = halted_q;
    assign step_count = step_count_q;

endmodule

// File: doc/step_ctrl.md
Name: step_ctrl

Overview:
- Consumer end of the slow clock produced by the clock divider.
- Brings the divided clock, a raw step push-button and a run/pause switch into the clk_in domain.
- Emits single-cycle cpu_en pulses that advance the single-cycle MIPS core, either free-running from the divided clock or one instruction per button press.
- Supports halt on CPU request and counts retired steps.

Parameters:
DEBOUNCE_CYCLES, 20, number of consecutive clk_in cycles a synchronized button level must differ from the accepted level before it is accepted (board build overrides to 2500000).
CNT_W, 32, width of step_count and the debounce counter.

Ports:
clk_in  input  1  system clock; all state on rising edge.
rst  input  1  reset, asynchronous, active-low (rst==0 resets immediately, independent of clk_in).
slow_clk  input  1  divided clock from divider; asynchronous to clk_in.
btn_step  input  1  raw manual step button, active-high, bouncy.
sw_run  input  1  raw run switch; 1 = run from slow_clk, 0 = manual step.
halt_req  input  1  CPU halt request, synchronous to clk_in, level.
cpu_en  output  1  one-cycle step enable to CPU.
running  output  1  1 while FSM is in RUN.
halted  output  1  1 while FSM is in HALT.
step_count  output  CNT_W  number of cpu_en pulses issued since reset.

Behaviour:
- Reset (rst==0): state=PAUSE; cpu_en=0, running=0, halted=0, step_count=0; all synchronizer/debounce flops and db_level=0, counter=0. Reset mid-operation clears everything asynchronously with no clock edge required.
- Synchronizers:
  - slow_clk, btn_step and sw_run each pass through two flops (s1, s2).
  - slow_clk has a third flop s3; tick = s2 & ~s3.
- Latency: slow_clk rise captured at edge k → tick during the cycle after edge k+1 → cpu_en high for exactly the one cycle following edge k+2.
- Debounce (btn path):
  - If s2 != db_level, the counter increments each cycle; if s2 == db_level, the counter clears.
  - When the counter equals DEBOUNCE_CYCLES-1 and s2 != db_level, db_level <= s2 and the counter clears.
  - press = db_level rising edge (registered previous value), one cycle wide.
  - Glitches shorter than DEBOUNCE_CYCLES produce nothing.
- FSM, evaluated on current state each edge:
  - PAUSE: step source = press. If sw_run sync == 1, next = RUN.
  - RUN: step source = tick. If sw_run sync == 0, next = PAUSE.
  - HALT: no step source; exits only via reset.
  - halt_req==1 in PAUSE or RUN: next = HALT; suppresses any cpu_en that cycle (halt has priority).
- cpu_en <= step source of current state, unless halt_req. Events of the other mode during a mode-change cycle are dropped.
- running = (state==RUN) and halted = (state==HALT), both registered from next state, i.e. valid the cycle after the transition edge.
- step_count increments by 1 on each edge where cpu_en is set. Wraps from 2^CNT_W-1 to 0, no saturation.
- Simultaneous tick and press: only the current mode's source is used, so at most one pulse per cycle.

Decomposition:
- Shared package step_pkg holds:
  - state encoding constants ST_PAUSE=2'd0, ST_RUN=2'd1, ST_HALT=2'd2;
  - default DEBOUNCE_CYCLES;
  - CNT_W.
- One sub-module, step_debounce: 2-flop synchronizer, debounce counter, db_level and press-edge output, parameterized by DEBOUNCE_CYCLES.
- slow_clk and sw_run synchronizers stay in step_ctrl.

Test Plan:
1. rst low 3 cycles then high, sw_run=1, slow_clk period 10 clk_in, 5 rising edges → 5 cpu_en pulses, each 1 cycle, first starting 3 edges after the slow_clk rise; step_count=5; running=1.
2. sw_run=0, btn_step bounces 6 times within 10 cycles then holds 1 for 40 cycles (DEBOUNCE_CYCLES=20) → exactly one cpu_en pulse, and the count goes 0→1. Then release with bounce → no further pulse.
3. sw_run=0, btn_step high 15 cycles then low → no cpu_en, step_count stays 0. Slow_clk keeps toggling → still no pulse.
4. RUN with halt_req=1 in the same cycle tick is high → cpu_en stays 0; halted=1 the next cycle; 10 further slow_clk edges and button presses give no pulses; count frozen.
5. rst driven 0 mid-RUN between clk_in edges → cpu_en, running, halted and step_count read 0 before the next edge. After release, the FSM is in PAUSE until sw_run sync is seen (running=1 two cycles later).
6. step_count forced to 32'hFFFFFFFF via preceding pulses (or CNT_W=4 build: 15 pulses), one more pulse → step_count=0, cpu_en still one cycle.
